// File: rtl/ledarray_frame_sequencer.sv
// LED array frame sequencer: streams a byte frame buffer to a pixel writer with
// a busy handshake, inter-byte gaps, a busy-rise timeout and periodic auto-refresh.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a pending frame request
// LOAD      | read buffer[idx] into px_value
// ISSUE     | px_valid strobe, arm the busy-rise timeout
// WAIT_BUSY | wait for px_busy to rise, abort the frame on timeout
// WAIT_DONE | wait for px_busy to fall
// GAP       | inter-byte idle time, then next byte or finish
// DONE      | frame_done pulse
module ledarray_frame_sequencer #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int GAP_CYCLES     = 24,
    parameter int BUSY_TIMEOUT   = 64,
    parameter int REFRESH_CYCLES = 200_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W:0]   frame_len,
    input  logic              frame_start,
    input  logic              refresh_en,
    input  logic              err_clr,
    output logic              px_valid,
    output logic [7:0]        px_value,
    input  logic              px_busy,
    output logic              frame_active,
    output logic              frame_done,
    output logic              err
);

    localparam int LW = ADDR_W + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_CYCLES + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [7:0]        mem [DEPTH];
    logic [2:0]        state;
    logic              pending;
    logic [LW-1:0]     len;
    logic [LW-1:0]     len_sel;
    logic [ADDR_W-1:0] idx;
    logic [TW-1:0]     tmo_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [RW-1:0]     ref_cnt;
    logic              refresh_tick;
    logic              accept;
    logic              timeout;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !refresh_en) begin
            ref_cnt <= '0;
        end else if (ref_cnt == RW'(REFRESH_CYCLES - 1)) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    assign refresh_tick = refresh_en && (ref_cnt == RW'(REFRESH_CYCLES - 1));
    assign len_sel      = (frame_len > DEPTH_L) ? DEPTH_L : frame_len;
    assign accept       = (state == S_IDLE) && pending;
    // Timeout lands so that err rises exactly BUSY_TIMEOUT cycles after the px_valid cycle.
    assign timeout      = (state == S_WAIT_BUSY) && !px_busy && (tmo_cnt <= TW'(1));

    assign px_valid     = (state == S_ISSUE);
    assign frame_done   = (state == S_DONE);
    assign frame_active = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pending  <= 1'b0;
            len      <= '0;
            idx      <= '0;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
            px_value <= '0;
            err      <= 1'b0;
        end else begin
            pending <= (pending && !accept) || frame_start || refresh_tick;

            if (timeout) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pending) begin
                        len   <= len_sel;
                        idx   <= '0;
                        state <= (len_sel == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    px_value <= mem[idx];
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    tmo_cnt <= TW'(BUSY_TIMEOUT - 1);
                    state   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (px_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (timeout) begin
                        state <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!px_busy) begin
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        if ({1'b0, idx} == len - LW'(1)) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= S_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ledarray_frame_sequencer.sv
// Directed bench for ledarray_frame_sequencer with a behavioural pixel-writer
// busy responder and a negedge monitor collecting strobes and frame starts.
module tb_ledarray_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [4:0] frame_len = '0;
    logic       frame_start = 1'b0;
    logic       refresh_en = 1'b0;
    logic       err_clr = 1'b0;
    logic       px_busy = 1'b0;
    logic       px_valid;
    logic [7:0] px_value;
    logic       frame_active;
    logic       frame_done;
    logic       err;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    bit resp_en = 1'b0;
    int nv = 0;
    int nd = 0;
    logic [7:0] val_q[$];
    int rise_q[$];
    logic act_d = 1'b0;

    ledarray_frame_sequencer #(
        .DEPTH(16), .ADDR_W(4), .GAP_CYCLES(24), .BUSY_TIMEOUT(64), .REFRESH_CYCLES(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_len(frame_len), .frame_start(frame_start), .refresh_en(refresh_en),
        .err_clr(err_clr), .px_valid(px_valid), .px_value(px_value), .px_busy(px_busy),
        .frame_active(frame_active), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (px_valid === 1'b1) begin
            nv++;
            val_q.push_back(px_value);
        end
        if (frame_done === 1'b1) nd++;
        if (frame_active === 1'b1 && act_d !== 1'b1) rise_q.push_back(cyc);
        act_d = frame_active;
    end

    // Pixel writer: busy rises 2 cycles after each strobe and stays high 50 cycles.
    always begin
        @(posedge clk); #1;
        if (resp_en && px_valid === 1'b1) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            px_busy = 1'b1;
            repeat (50) begin @(posedge clk); #1; end
            px_busy = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        nv = 0;
        nd = 0;
        val_q.delete();
        rise_q.delete();
    endtask

    task automatic wr_byte(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(output int c0);
        c0 = cyc;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        nvec++; if (px_valid !== 1'b0) begin nerr++; $display("FAIL reset_px_valid: got %b want 0", px_valid); end
        nvec++; if (px_value !== 8'h00) begin nerr++; $display("FAIL reset_px_value: got %h want 00", px_value); end
        nvec++; if (frame_active !== 1'b0) begin nerr++; $display("FAIL reset_frame_active: got %b want 0", frame_active); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_frame();
        int c0;
        logic [7:0] e;
        for (int i = 0; i < 4; i++) wr_byte(4'(i), 8'((i + 1) * 17));
        resp_en = 1'b1;
        frame_len = 5'd4;
        clear_mon();
        pulse_start(c0);
        for (int i = 0; i < 2000 && nd == 0; i++) step();
        step(); step();
        nvec++; if (nd != 1) begin nerr++; $display("FAIL frame_done_count: got %0d want 1", nd); end
        nvec++; if (nv != 4) begin nerr++; $display("FAIL frame_valid_count: got %0d want 4", nv); end
        for (int i = 0; i < 4; i++) begin
            e = 8'((i + 1) * 17);
            nvec++;
            if (i >= val_q.size()) begin nerr++; $display("FAIL frame_value[%0d]: missing want %h", i, e); end
            else if (val_q[i] !== e) begin nerr++; $display("FAIL frame_value[%0d]: got %h want %h", i, val_q[i], e); end
        end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL frame_err: got %b want 0", err); end
        nvec++; if (frame_active !== 1'b0) begin nerr++; $display("FAIL frame_idle_after: got %b want 0", frame_active); end
        nvec++;
        if (rise_q.size() < 1) begin nerr++; $display("FAIL frame_start_latency: no frame_active rise"); end
        else if (rise_q[0] != c0 + 2) begin nerr++; $display("FAIL frame_start_latency: got %0d want %0d", rise_q[0], c0 + 2); end
    endtask

    task automatic test_zero_len();
        int c0;
        frame_len = 5'd0;
        clear_mon();
        pulse_start(c0);
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL zero_done_c1: got %b want 0", frame_done); end
        step();
        nvec++; if (frame_done !== 1'b1) begin nerr++; $display("FAIL zero_done_c2: got %b want 1", frame_done); end
        step();
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL zero_done_c3: got %b want 0", frame_done); end
        nvec++; if (frame_active !== 1'b0) begin nerr++; $display("FAIL zero_active_c3: got %b want 0", frame_active); end
        repeat (10) step();
        nvec++; if (nv != 0) begin nerr++; $display("FAIL zero_no_valid: got %0d want 0", nv); end
    endtask

    task automatic test_timeout();
        int c0;
        resp_en = 1'b0;
        frame_len = 5'd1;
        clear_mon();
        pulse_start(c0);
        for (int i = 0; i < 20 && px_valid !== 1'b1; i++) step();
        nvec++; if (px_valid !== 1'b1) begin nerr++; $display("FAIL tmo_valid_seen: got %b want 1", px_valid); end
        repeat (63) step();
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL tmo_err_early: got %b want 0", err); end
        step();
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL tmo_err_at_64: got %b want 1", err); end
        nvec++; if (frame_done !== 1'b1) begin nerr++; $display("FAIL tmo_frame_done: got %b want 1", frame_done); end
        step();
        nvec++; if (frame_active !== 1'b0) begin nerr++; $display("FAIL tmo_idle: got %b want 0", frame_active); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL tmo_err_clr: got %b want 0", err); end
        // err_clr in the very cycle the timeout fires must lose to the timeout
        pulse_start(c0);
        for (int i = 0; i < 20 && px_valid !== 1'b1; i++) step();
        repeat (63) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL tmo_clr_collide: got %b want 1", err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int c0;
        resp_en = 1'b1;
        frame_len = 5'd2;
        clear_mon();
        pulse_start(c0);
        repeat (20) step();
        pulse_start(c0);
        repeat (20) step();
        pulse_start(c0);
        for (int i = 0; i < 2000 && nd < 2; i++) step();
        repeat (300) step();
        nvec++; if (nd != 2) begin nerr++; $display("FAIL b2b_frames: got %0d want 2", nd); end
        nvec++; if (nv != 4) begin nerr++; $display("FAIL b2b_valids: got %0d want 4", nv); end
        nvec++; if (rise_q.size() != 2) begin nerr++; $display("FAIL b2b_starts: got %0d want 2", rise_q.size()); end
    endtask

    task automatic test_len_clamp();
        int c0;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) wr_byte(4'(i), 8'(8'hA0 + i));
        resp_en = 1'b1;
        frame_len = 5'd20;
        clear_mon();
        pulse_start(c0);
        wr_byte(4'd15, 8'hEE);
        for (int i = 0; i < 3000 && nd == 0; i++) step();
        step(); step();
        nvec++; if (nv != 16) begin nerr++; $display("FAIL clamp_valid_count: got %0d want 16", nv); end
        nvec++; if (nd != 1) begin nerr++; $display("FAIL clamp_done_count: got %0d want 1", nd); end
        for (int i = 0; i < 16; i++) begin
            e = (i == 15) ? 8'hEE : 8'(8'hA0 + i);
            nvec++;
            if (i >= val_q.size()) begin nerr++; $display("FAIL clamp_value[%0d]: missing want %h", i, e); end
            else if (val_q[i] !== e) begin nerr++; $display("FAIL clamp_value[%0d]: got %h want %h", i, val_q[i], e); end
        end
    endtask

    task automatic test_refresh();
        int c0;
        resp_en = 1'b1;
        frame_len = 5'd1;
        clear_mon();
        c0 = cyc;
        refresh_en = 1'b1;
        for (int i = 0; i < 3200; i++) step();
        refresh_en = 1'b0;
        repeat (100) step();
        nvec++; if (nd != 3) begin nerr++; $display("FAIL refresh_frames: got %0d want 3", nd); end
        nvec++;
        if (rise_q.size() != 3) begin nerr++; $display("FAIL refresh_starts: got %0d want 3", rise_q.size()); end
        else begin
            if (rise_q[0] != c0 + 1001) begin nerr++; $display("FAIL refresh_first: got %0d want %0d", rise_q[0], c0 + 1001); end
            nvec++; if (rise_q[1] - rise_q[0] != 1000) begin nerr++; $display("FAIL refresh_period1: got %0d want 1000", rise_q[1] - rise_q[0]); end
            nvec++; if (rise_q[2] - rise_q[1] != 1000) begin nerr++; $display("FAIL refresh_period2: got %0d want 1000", rise_q[2] - rise_q[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        resp_en = 1'b1;
        frame_len = 5'd1;
        clear_mon();
        pulse_start(c0);
        for (int i = 0; i < 20 && px_busy !== 1'b1; i++) step();
        repeat (3) step();
        nvec++; if (frame_active !== 1'b1) begin nerr++; $display("FAIL rstmid_active_before: got %b want 1", frame_active); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        nvec++; if (frame_active !== 1'b0) begin nerr++; $display("FAIL rstmid_active: got %b want 0", frame_active); end
        nvec++; if (px_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_px_valid: got %b want 0", px_valid); end
        nvec++; if (px_value !== 8'h00) begin nerr++; $display("FAIL rstmid_px_value: got %h want 00", px_value); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL rstmid_frame_done: got %b want 0", frame_done); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rstmid_err: got %b want 0", err); end
        repeat (100) step();
        nvec++; if (nd != 0) begin nerr++; $display("FAIL rstmid_no_done: got %0d want 0", nd); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_zero_len();
        test_timeout();
        test_back_to_back();
        test_len_clamp();
        test_refresh();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ledarray_frame_sequencer.md
LEDARRAY_FRAME_SEQUENCER -- requirements
Module: ledarray_frame_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: frame buffer size in bytes.
REQ-002 SHALL have parameter ADDR_W, default 4: frame buffer address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter GAP_CYCLES, default 24: idle clk cycles between consecutive bytes.
REQ-004 SHALL have parameter BUSY_TIMEOUT, default 64: max clk cycles to wait for px_busy to rise after px_valid.
REQ-005 SHALL have parameter REFRESH_CYCLES, default 200_000: clk cycles between auto-refresh frame requests.
REQ-006 SHALL have one clock and a synchronous, active-low reset: clk  in  1  system clock, all logic on posedge.
REQ-007 SHALL have rst_n  in  1  synchronous active-low reset.
REQ-008 SHALL have wr_en  in  1  frame buffer write strobe.
REQ-009 SHALL have wr_addr  in  ADDR_W  frame buffer write address.
REQ-010 SHALL have wr_data  in  8  frame buffer write data.
REQ-011 SHALL have frame_len  in  ADDR_W+1  bytes per frame, sampled at frame start.
REQ-012 SHALL have frame_start  in  1  one-cycle frame request pulse.
REQ-013 SHALL have refresh_en  in  1  enables periodic auto-refresh requests.
REQ-014 SHALL have err_clr  in  1  clears err.
REQ-015 SHALL have px_valid  out  1  one-cycle byte strobe to pixel writer.
REQ-016 SHALL have px_value  out  8  byte to pixel writer, valid with px_valid.
REQ-017 SHALL have px_busy  in  1  pixel writer busy.
REQ-018 SHALL have frame_active, frame_done, err  out  1 each: frame in progress / one-cycle frame-complete pulse / sticky timeout flag.

Function
REQ-019 SHALL write wr_data to buffer[wr_addr] on any clk with wr_en=1, in any state; a byte is read at its LOAD cycle, so writes to not-yet-loaded bytes take effect in the current frame.
REQ-020 SHALL implement states IDLE, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, GAP, DONE.
REQ-021 SHALL, in IDLE with a pending request, latch len = min(frame_len, DEPTH), clear idx, go to LOAD; if len = 0, go directly to DONE.
REQ-022 SHALL, in LOAD, register buffer[idx] into px_value and go to ISSUE.
REQ-023 SHALL, in ISSUE, drive px_valid=1 for exactly one cycle, clear the timeout counter, and go to WAIT_BUSY.
REQ-024 SHALL, in WAIT_BUSY, go to WAIT_DONE when px_busy=1; after BUSY_TIMEOUT cycles without px_busy, set err and go to DONE (frame aborted).
REQ-025 SHALL, in WAIT_DONE, go to GAP when px_busy=0.
REQ-026 SHALL, in GAP, count GAP_CYCLES cycles, then go to DONE if idx = len-1, else increment idx and go to LOAD.
REQ-027 SHALL, in DONE, pulse frame_done for one cycle and return to IDLE.
REQ-028 SHALL assert frame_active in every state except IDLE.
REQ-029 SHALL hold a single pending-request bit, set by frame_start or a refresh tick in any state, cleared when IDLE accepts it; multiple requests during a frame collapse to one.
REQ-030 SHALL, while refresh_en=1, count 0..REFRESH_CYCLES-1 and raise a refresh tick at wrap; refresh_en=0 holds the counter at 0.
REQ-031 SHALL keep px_value stable from ISSUE until the next LOAD.
REQ-032 SHALL clear err on err_clr=1; a timeout coinciding with err_clr leaves err=1.

Reset
REQ-033 SHALL, on rst_n=0 at a clk edge, enter IDLE and clear px_valid, px_value, frame_active, frame_done, err, pending, idx, and all counters; buffer contents are not cleared.
REQ-034 SHALL abort a frame in progress on reset with no frame_done pulse.

Verification
REQ-035 SHALL cover: write buffer 0..3 = 0x11,0x22,0x33,0x44, frame_len=4, frame_start, model busy 2 cycles after each valid for 50 cycles -> four px_valid pulses with values 0x11,0x22,0x33,0x44 in order, then one frame_done, err=0.
REQ-036 SHALL cover: frame_len=0, frame_start -> no px_valid, frame_done two cycles later.
REQ-037 SHALL cover: px_busy held 0 -> err=1 exactly 64 cycles after px_valid, frame_done pulse, return to IDLE; err_clr -> err=0.
REQ-038 SHALL cover: two frame_start pulses during an active frame -> exactly one extra frame after the first.
REQ-039 SHALL cover: refresh_en=1, REFRESH_CYCLES=1000 -> frame starts every 1000 cycles when idle.
REQ-040 SHALL cover: rst_n=0 mid-WAIT_DONE -> next cycle IDLE, all outputs 0, no frame_done.
